// File: rtl/pdm_mic_emulator.sv
// pdm_mic_emulator: emulates a PDM microphone by feeding FIFO-buffered PCM samples
// through a second-order sigma-delta modulator clocked by ticks derived from mic_clk.
module pdm_mic_emulator #(
    parameter int DW         = 18,
    parameter int DECIM      = 500,
    parameter int FIFO_DEPTH = 4,
    parameter int CLAMP      = 98304
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          mic_clk,
    input  logic [DW-1:0]                 i_data,
    input  logic                          i_vld,
    output logic                          o_rdy,
    output logic                          mic_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underrun
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DECIM);
    localparam int A1W = DW + 4;
    localparam int A2W = DW + 8;
    localparam int SW  = A2W + 2;
    localparam logic signed [DW-1:0] CMAX  = DW'(CLAMP);
    localparam logic signed [DW-1:0] CMIN  = -CMAX;
    localparam logic signed [SW-1:0] FBP   = SW'(2 ** (DW - 1));
    localparam logic signed [SW-1:0] FBN   = -FBP;
    localparam logic signed [SW-1:0] A1MAX = SW'(2 ** (A1W - 1) - 1);
    localparam logic signed [SW-1:0] A1MIN = SW'(-(2 ** (A1W - 1)));
    localparam logic signed [SW-1:0] A2MAX = SW'(2 ** (A2W - 1) - 1);
    localparam logic signed [SW-1:0] A2MIN = SW'(-(2 ** (A2W - 1)));

    logic [2:0]                  sync_q, sync_d;
    logic signed [DW-1:0]        mem_q [FIFO_DEPTH];
    logic signed [DW-1:0]        mem_d [FIFO_DEPTH];
    logic [AW-1:0]               wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]               level_q, level_d;
    logic                        rdy_q, rdy_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [DW-1:0]        hold_q, hold_d;
    logic signed [A1W-1:0]       acc1_q, acc1_d;
    logic signed [A2W-1:0]       acc2_q, acc2_d;
    logic                        bit_q, bit_d;
    logic                        udr_q, udr_d;
    logic                        tick, wrap, push, pop;
    logic signed [DW-1:0]        head, x;
    logic signed [SW-1:0]        fb, s1, s2;
    logic signed [A1W-1:0]       a1n;
    logic signed [A2W-1:0]       a2n;

    always_comb begin
        sync_d  = {sync_q[1], sync_q[0], mic_clk};
        tick    = sync_q[1] & ~sync_q[2];
        wrap    = tick && (cnt_q == CW'(DECIM - 1));
        pop     = wrap && (level_q != '0);
        push    = i_vld && rdy_q;
        mem_d   = mem_q;
        if (push)
            mem_d[wp_q] = i_data;
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        level_d = level_q + LW'(push) - LW'(pop);
        rdy_d   = level_d < LW'(FIFO_DEPTH);
        cnt_d   = tick ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        udr_d   = udr_q | (wrap && (level_q == '0));
        head    = mem_q[rp_q];
        x       = (head > CMAX) ? CMAX : (head < CMIN) ? CMIN : head;
        // the newly popped sample only takes effect from the following tick
        hold_d  = pop ? x : hold_q;
        fb      = bit_q ? FBP : FBN;
        s1      = acc1_q + hold_q - fb;
        a1n     = (s1 > A1MAX) ? A1W'(A1MAX) : (s1 < A1MIN) ? A1W'(A1MIN) : A1W'(s1);
        s2      = acc2_q + a1n - fb;
        a2n     = (s2 > A2MAX) ? A2W'(A2MAX) : (s2 < A2MIN) ? A2W'(A2MIN) : A2W'(s2);
        acc1_d  = tick ? a1n : acc1_q;
        acc2_d  = tick ? a2n : acc2_q;
        bit_d   = tick ? ~a2n[A2W-1] : bit_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q  <= '0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
            hold_q  <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            bit_q   <= 1'b0;
            udr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            bit_q   <= bit_d;
            udr_q   <= udr_d;
        end
    end

    assign o_rdy      = rdy_q;
    assign mic_data   = bit_q;
    assign o_level    = level_q;
    assign o_underrun = udr_q;
endmodule

// File: tb/tb_pdm_mic_emulator.sv
// tb_pdm_mic_emulator: scoreboard bench; a sample-level model predicts every PDM bit,
// FIFO level and underrun flag, and a monitor compares the bits as they appear.
module tb_pdm_mic_emulator;
    localparam int DW = 18, DECIM = 500, FD = 4, NS = 10, NT = 6000;

    logic          CLK = 0, RST = 1, mic_clk = 0, i_vld = 0;
    logic [DW-1:0] i_data = '0;
    logic          o_rdy, mic_data, o_underrun;
    logic [2:0]    o_level;

    always #5 CLK = ~CLK;

    pdm_mic_emulator #(.DW(DW), .DECIM(DECIM), .FIFO_DEPTH(FD), .CLAMP(98304)) dut (
        .CLK(CLK), .RST(RST), .mic_clk(mic_clk), .i_data(i_data), .i_vld(i_vld),
        .o_rdy(o_rdy), .mic_data(mic_data), .o_level(o_level), .o_underrun(o_underrun)
    );

    int     total = 0, bad = 0;
    longint acc1 = 0, acc2 = 0;
    int     hold_m = 0, tcnt = 0, sp = 0, mon_n = 0;
    bit     pb = 0, und_m = 0;
    int     mq[$];
    bit     exp_q[$];
    int     ones[16] = '{default: 0};
    int     sched[NS] = '{0, 0, 65536, 65536, -65536, -65536, 131071, 131071, 0, 0};

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tcnt);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint lim = 64'sd1 <<< (w - 1);
        return v >= lim ? lim - 1 : (v < -lim ? -lim : v);
    endfunction

    function automatic int clampv(input int v);
        return v > 98304 ? 98304 : (v < -98304 ? -98304 : v);
    endfunction

    // one modulator step on the held sample, then the end-of-period FIFO pop
    task automatic model_tick();
        longint fb = pb ? 131072 : -131072;
        acc1 = sat(acc1 + hold_m - fb, DW + 4);
        acc2 = sat(acc2 + acc1 - fb, DW + 8);
        pb   = acc2 >= 0;
        exp_q.push_back(pb);
        if (tcnt % DECIM == DECIM - 1) begin
            if (mq.size() > 0) hold_m = clampv(mq.pop_front());
            else und_m = 1;
        end
        tcnt++;
    endtask

    task automatic push1(input int v);
        check("rdy_before_push", o_rdy, mq.size() < FD);
        i_vld  = 1;
        i_data = DW'(v);
        @(posedge CLK);
        if (mq.size() < FD) mq.push_back(v);
        @(negedge CLK);
        i_vld = 0;
        check("level_after_push", o_level, mq.size());
    endtask

    task automatic do_tick(input bit feed);
        mic_clk = 1;
        model_tick();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("level", o_level, mq.size());
        check("underrun", o_underrun, und_m);
        mic_clk = 0;
        if (feed && sp < NS && mq.size() < FD) begin
            push1(sched[sp]);
            sp++;
        end else @(negedge CLK);
        repeat (4) @(negedge CLK);
    endtask

    initial forever begin : monitor
        bit e;
        @(posedge mic_clk);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mic_data: bit observed with no expected value queued");
        end else begin
            e = exp_q.pop_front();
            check("mic_data", mic_data, e);
        end
        if (mon_n / DECIM < 16) ones[mon_n / DECIM] += int'(mic_data);
        mon_n++;
    end

    initial begin
        int   v;
        real  e;
        int   wins[5] = '{1, 2, 4, 6, 8};
        int   wx[5]   = '{0, 0, 65536, -65536, 98304};
        sched[8] = int'($urandom_range(0, 262143)) - 131072;
        sched[9] = int'($urandom_range(0, 262143)) - 131072;
        repeat (3) @(negedge CLK);
        check("reset_rdy", o_rdy, 1);
        check("reset_level", o_level, 0);
        check("reset_mic", mic_data, 0);
        check("reset_underrun", o_underrun, 0);
        RST = 0;
        @(negedge CLK);
        // five back-to-back pushes with no ticks: only four fit
        i_vld = 1;
        for (int k = 0; k < 5; k++) begin
            v = k < 4 ? sched[k] : 12345;
            check("rdy_fill", o_rdy, mq.size() < FD);
            i_data = DW'(v);
            @(posedge CLK);
            if (mq.size() < FD) mq.push_back(v);
            @(negedge CLK);
        end
        i_vld = 0;
        check("full_level", o_level, 4);
        check("full_rdy", o_rdy, 0);
        sp = 4;
        for (int t = 0; t < NT; t++) do_tick(1);
        repeat (2) @(negedge CLK);
        check("bits_seen", mon_n, NT);
        check("underrun_sticky", o_underrun, 1);
        for (int i = 0; i < 5; i++) begin
            e = 250.0 * (1.0 + real'(wx[i]) / 131072.0);
            total++;
            if (real'(ones[wins[i]]) < e - 2.0 || real'(ones[wins[i]]) > e + 2.0) begin
                bad++;
                $display("FAIL density_w%0d: got %0d ones expected %0.1f +/-2", wins[i], ones[wins[i]], e);
            end
        end
        push1(777);
        push1(-5);
        for (int t = 0; t < 3; t++) do_tick(0);
        check("pre_reset_level", o_level, 2);
        #2 RST = 1;
        #1;
        check("async_rst_mic", mic_data, 0);
        check("async_rst_level", o_level, 0);
        check("async_rst_rdy", o_rdy, 1);
        check("async_rst_underrun", o_underrun, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
